conv2d_seq_ctrl: RTL

Sequencer for one 3x3 conv2D engine (32-bit float, line-buffer based). On `start` it:
- clears the engine;
- streams a WIDTH x HEIGHT feature map from an input buffer into the engine at one pixel per cycle;
- keeps only the engine outputs that are valid (non-wrapping) windows and writes them densely to an output buffer;
- reports done or timeout.

It sits between the layer scheduler and the per-channel conv2D instance.

---
 rtl/conv2d_seq_ctrl.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/conv2d_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : conv2d_seq_ctrl
// Purpose  : Clears a 3x3 conv2D engine, streams a WIDTH x HEIGHT map into it
//            and packs the non-wrapping windows into an output buffer.
//            Optional cycle counter port enabled by CONV2D_SEQ_CTRL_PERF_EN.
// Revision : 1.0  initial release
// ============================================================================
module conv2d_seq_ctrl #(
    parameter int DATA_WIDTH    = 32,
    parameter int WIDTH         = 5,
    parameter int HEIGHT        = 5,
    parameter int ADDR_WIDTH    = 10,
    parameter int DRAIN_TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  timeout_err,
    output logic                  in_rd_en,
    output logic [ADDR_WIDTH-1:0] in_addr,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  conv_rst,
    output logic                  conv_wren,
    output logic [DATA_WIDTH-1:0] conv_data_in,
    input  logic                  conv_valid_out,
    input  logic [DATA_WIDTH-1:0] conv_data_out,
`ifdef CONV2D_SEQ_CTRL_PERF_EN
    output logic [31:0]           perf_cycles,
`endif
    output logic                  out_wr_en,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic [DATA_WIDTH-1:0] out_data
);

    localparam logic [ADDR_WIDTH-1:0] c_LAST_PIX   = ADDR_WIDTH'(WIDTH * HEIGHT - 1);
    localparam logic [ADDR_WIDTH-1:0] c_LAST_KEEP  = ADDR_WIDTH'((WIDTH - 2) * (HEIGHT - 2) - 1);
    localparam logic [ADDR_WIDTH-1:0] c_COL_FIRST  = ADDR_WIDTH'((2 * WIDTH + 2) % WIDTH);
    localparam logic [ADDR_WIDTH-1:0] c_COL_LAST   = ADDR_WIDTH'(WIDTH - 1);
    localparam logic [ADDR_WIDTH-1:0] c_COL_MIN    = ADDR_WIDTH'(2);
    localparam logic [ADDR_WIDTH-1:0] c_DRAIN_LAST = ADDR_WIDTH'(DRAIN_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLR   = 3'd1,
        S_LOAD  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                r_state;
    logic                  r_conv_rst;
    logic [ADDR_WIDTH-1:0] r_col;
    logic [ADDR_WIDTH-1:0] r_kept;
    logic [ADDR_WIDTH-1:0] r_drain_cnt;
    logic                  w_active;
    logic                  w_keep;
    logic                  w_last_keep;

    // Engine results only count while the map is in flight; the first result
    // belongs to pixel 2*WIDTH+2, so the column tracker is seeded from there.
    assign w_active    = (r_state == S_LOAD) || (r_state == S_DRAIN);
    assign w_keep      = w_active && conv_valid_out && (r_col >= c_COL_MIN);
    assign w_last_keep = w_keep && (r_kept == c_LAST_KEEP);

    // The engine must be cleared for as long as the controller itself is in reset.
    assign conv_rst = rst || r_conv_rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_conv_rst   <= 1'b0;
            r_col        <= '0;
            r_kept       <= '0;
            r_drain_cnt  <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            timeout_err  <= 1'b0;
            in_rd_en     <= 1'b0;
            in_addr      <= '0;
            conv_wren    <= 1'b0;
            conv_data_in <= '0;
            out_wr_en    <= 1'b0;
            out_addr     <= '0;
            out_data     <= '0;
        end else begin
            conv_wren    <= in_rd_en;
            conv_data_in <= in_data;
            out_wr_en    <= 1'b0;
            done         <= 1'b0;
            r_conv_rst   <= 1'b0;

            if (w_active && conv_valid_out) begin
                r_col <= (r_col == c_COL_LAST) ? '0 : r_col + 1'b1;
                if (w_keep) begin
                    out_wr_en <= 1'b1;
                    out_addr  <= r_kept;
                    out_data  <= conv_data_out;
                    r_kept    <= r_kept + 1'b1;
                end
            end

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state     <= S_CLR;
                        busy        <= 1'b1;
                        timeout_err <= 1'b0;
                        r_conv_rst  <= 1'b1;
                    end
                end
                S_CLR: begin
                    r_state     <= S_LOAD;
                    in_rd_en    <= 1'b1;
                    in_addr     <= '0;
                    r_col       <= c_COL_FIRST;
                    r_kept      <= '0;
                    r_drain_cnt <= '0;
                end
                S_LOAD: begin
                    if (w_last_keep) begin
                        r_state  <= S_DONE;
                        done     <= 1'b1;
                        in_rd_en <= 1'b0;
                    end else if (in_addr == c_LAST_PIX) begin
                        r_state  <= S_DRAIN;
                        in_rd_en <= 1'b0;
                    end else begin
                        in_addr <= in_addr + 1'b1;
                    end
                end
                S_DRAIN: begin
                    // A final write landing on the timeout cycle wins: no error.
                    if (w_last_keep) begin
                        r_state <= S_DONE;
                        done    <= 1'b1;
                    end else if (r_drain_cnt == c_DRAIN_LAST) begin
                        r_state     <= S_DONE;
                        done        <= 1'b1;
                        timeout_err <= 1'b1;
                    end else begin
                        r_drain_cnt <= r_drain_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef CONV2D_SEQ_CTRL_PERF_EN
    // Starts at 1 so the accepted-start cycle itself is included.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_cycles <= '0;
        end else if (r_state == S_IDLE) begin
            if (start) begin
                perf_cycles <= 32'd1;
            end
        end else begin
            perf_cycles <= perf_cycles + 32'd1;
        end
    end
`endif

endmodule
`default_nettype wire
